// File: rtl/talon_draw.sv
// Talon/stock pile controller: loads the face-down talon, services draw-N and take
// requests, and recycles the face-up stock back into the talon when it runs dry.
module talon_draw #(
  parameter int DRAW_N = 3,
  parameter int DEPTH  = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  logic [6:0] load_card,
  input  logic       load_last,
  output logic       load_ready,
  input  logic       draw_req,
  input  logic       take_req,
  output logic       take_valid,
  output logic [6:0] take_card,
  output logic       busy,
  output logic       done,
  output logic       ready,
  output logic [4:0] talon_count,
  output logic [4:0] stock_count,
  output logic [6:0] stock_top0,
  output logic [6:0] stock_top1,
  output logic [6:0] stock_top2,
  output logic [3:0] recycle_count
);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_READY   = 2'd1,
    S_DRAW    = 2'd2,
    S_RECYCLE = 2'd3
  } state_t;

  localparam logic [4:0] DEPTH_C = 5'(DEPTH);
  localparam logic [4:0] DRAW_C  = 5'(DRAW_N);

  state_t     state_r;
  state_t     state_nx_s;
  logic [6:0] talon_mem_r [0:DEPTH-1];
  logic [6:0] stock_mem_r [0:DEPTH-1];
  logic [4:0] talon_cnt_r;
  logic [4:0] stock_cnt_r;
  logic [4:0] remain_r;
  logic [3:0] recycle_cnt_r;
  logic       take_valid_r;
  logic [6:0] take_card_r;
  logic       done_r;
  logic [6:0] talon_top_s;
  logic [6:0] stock_top0_s;
  logic [6:0] stock_top1_s;
  logic [6:0] stock_top2_s;
  logic [4:0] draw_n_s;
  logic       load_wr_s;
  logic       take_go_s;
  logic       draw_go_s;
  logic       recy_go_s;
  logic       idle_draw_s;

  // Take wins over draw whenever asserted, even if the stock is empty.
  assign load_wr_s   = (state_r == S_LOAD) && load_valid && (load_card != 7'h00) && (talon_cnt_r < DEPTH_C);
  assign take_go_s   = (state_r == S_READY) && take_req && (stock_cnt_r != 5'd0);
  assign draw_go_s   = (state_r == S_READY) && !take_req && draw_req && (talon_cnt_r != 5'd0);
  assign recy_go_s   = (state_r == S_READY) && !take_req && draw_req && (talon_cnt_r == 5'd0) && (stock_cnt_r != 5'd0);
  assign idle_draw_s = (state_r == S_READY) && !take_req && draw_req && (talon_cnt_r == 5'd0) && (stock_cnt_r == 5'd0);
  assign draw_n_s    = (talon_cnt_r < DRAW_C) ? talon_cnt_r : DRAW_C;

  // Combinational pile-top reads of the registered memories.
  always_comb begin
    talon_top_s  = 7'h00;
    stock_top0_s = 7'h00;
    stock_top1_s = 7'h00;
    stock_top2_s = 7'h00;
    if (talon_cnt_r >= 5'd1) talon_top_s = talon_mem_r[talon_cnt_r - 5'd1];
    else                     talon_top_s = 7'h00;
    if (stock_cnt_r >= 5'd1) stock_top0_s = stock_mem_r[stock_cnt_r - 5'd1];
    else                     stock_top0_s = 7'h00;
    if (stock_cnt_r >= 5'd2) stock_top1_s = stock_mem_r[stock_cnt_r - 5'd2];
    else                     stock_top1_s = 7'h00;
    if (stock_cnt_r >= 5'd3) stock_top2_s = stock_mem_r[stock_cnt_r - 5'd3];
    else                     stock_top2_s = 7'h00;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_LOAD;
    else     state_r <= state_nx_s;
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_LOAD: begin
        if (load_valid && (load_last || ((load_card != 7'h00) && (talon_cnt_r == DEPTH_C - 5'd1))))
          state_nx_s = S_READY;
        else
          state_nx_s = S_LOAD;
      end
      S_READY: begin
        if (draw_go_s)      state_nx_s = S_DRAW;
        else if (recy_go_s) state_nx_s = S_RECYCLE;
        else                state_nx_s = S_READY;
      end
      S_DRAW: begin
        if (remain_r <= 5'd1) state_nx_s = S_READY;
        else                  state_nx_s = S_DRAW;
      end
      S_RECYCLE: begin
        if (stock_cnt_r <= 5'd1) state_nx_s = S_READY;
        else                     state_nx_s = S_RECYCLE;
      end
      default: state_nx_s = S_LOAD;
    endcase
  end

  // State-decoded handshake and status outputs.
  always_comb begin
    load_ready = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    case (state_r)
      S_LOAD:             load_ready = 1'b1;
      S_READY:            ready      = 1'b1;
      S_DRAW, S_RECYCLE:  busy       = 1'b1;
      default:            load_ready = 1'b0;
    endcase
  end

  // Counters, take response and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      talon_cnt_r   <= 5'd0;
      stock_cnt_r   <= 5'd0;
      remain_r      <= 5'd0;
      recycle_cnt_r <= 4'd0;
      take_valid_r  <= 1'b0;
      take_card_r   <= 7'h00;
      done_r        <= 1'b0;
    end else begin
      take_valid_r <= 1'b0;
      done_r       <= 1'b0;
      case (state_r)
        S_LOAD: begin
          if (load_wr_s) talon_cnt_r <= talon_cnt_r + 5'd1;
        end
        S_READY: begin
          if (take_go_s) begin
            stock_cnt_r  <= stock_cnt_r - 5'd1;
            take_card_r  <= stock_top0_s;
            take_valid_r <= 1'b1;
          end else if (draw_go_s) begin
            remain_r <= draw_n_s;
          end else if (recy_go_s) begin
            if (recycle_cnt_r != 4'hF) recycle_cnt_r <= recycle_cnt_r + 4'd1;
          end else if (idle_draw_s) begin
            done_r <= 1'b1;
          end
        end
        S_DRAW: begin
          talon_cnt_r <= talon_cnt_r - 5'd1;
          stock_cnt_r <= stock_cnt_r + 5'd1;
          remain_r    <= remain_r - 5'd1;
          done_r      <= (remain_r == 5'd1);
        end
        S_RECYCLE: begin
          stock_cnt_r <= stock_cnt_r - 5'd1;
          talon_cnt_r <= talon_cnt_r + 5'd1;
          done_r      <= (stock_cnt_r == 5'd1);
        end
        default: done_r <= 1'b0;
      endcase
    end
  end

  // Pile storage; contents are don't-care after reset so no reset branch.
  always_ff @(posedge clk) begin
    if (load_wr_s)
      talon_mem_r[talon_cnt_r] <= {load_card[6:1], 1'b0};
    else if ((state_r == S_DRAW) && (remain_r != 5'd0) && (stock_cnt_r < DEPTH_C))
      stock_mem_r[stock_cnt_r] <= talon_top_s | 7'h01;
    else if ((state_r == S_RECYCLE) && (stock_cnt_r != 5'd0) && (talon_cnt_r < DEPTH_C))
      talon_mem_r[talon_cnt_r] <= stock_top0_s & 7'h7E;
  end

  assign take_valid    = take_valid_r;
  assign take_card     = take_card_r;
  assign done          = done_r;
  assign talon_count   = talon_cnt_r;
  assign stock_count   = stock_cnt_r;
  assign stock_top0    = stock_top0_s;
  assign stock_top1    = stock_top1_s;
  assign stock_top2    = stock_top2_s;
  assign recycle_count = recycle_cnt_r;

endmodule

// File: tb/tb_talon_draw.sv
// Scoreboard bench for talon_draw: drivers push expected take/done events, a negedge
// monitor pops and compares them whenever the DUT pulses take_valid or done.
module tb_talon_draw;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [6:0] load_card;
  logic       load_last;
  logic       load_ready;
  logic       draw_req;
  logic       take_req;
  logic       take_valid;
  logic [6:0] take_card;
  logic       busy;
  logic       done;
  logic       ready;
  logic [4:0] talon_count;
  logic [4:0] stock_count;
  logic [6:0] stock_top0;
  logic [6:0] stock_top1;
  logic [6:0] stock_top2;
  logic [3:0] recycle_count;

  talon_draw #(.DRAW_N(3), .DEPTH(24)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_card(load_card), .load_last(load_last), .load_ready(load_ready),
    .draw_req(draw_req), .take_req(take_req),
    .take_valid(take_valid), .take_card(take_card),
    .busy(busy), .done(done), .ready(ready),
    .talon_count(talon_count), .stock_count(stock_count),
    .stock_top0(stock_top0), .stock_top1(stock_top1), .stock_top2(stock_top2),
    .recycle_count(recycle_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_take;
    logic [6:0] card;
    int         cyc;
    int         tc;
    int         sc;
    logic [6:0] top0;
  } exp_t;

  exp_t       sb[$];
  logic [6:0] m_talon[$];
  logic [6:0] m_stock[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every take_valid / done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (take_valid === 1'b1) begin
        if (sb.size() == 0 || !sb[0].is_take) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_take: got card 0x%0h, expected no take (cycle %0d)", take_card, cyc);
        end else begin
          e = sb.pop_front();
          chk("take_card", 32'(take_card), 32'(e.card));
          chk("take_cycle", 32'(cyc), 32'(e.cyc));
          chk("take_stock_count", 32'(stock_count), 32'(e.sc));
        end
      end
      if (done === 1'b1) begin
        if (sb.size() == 0 || sb[0].is_take) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("done_talon_count", 32'(talon_count), 32'(e.tc));
          chk("done_stock_count", 32'(stock_count), 32'(e.sc));
          chk("done_stock_top0", 32'(stock_top0), 32'(e.top0));
          chk("done_ready", 32'(ready), 32'(1));
          chk("done_busy", 32'(busy), 32'(0));
        end
      end
    end
  end

  task automatic drain(input int budget);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk("events_pending", 32'(sb.size()), 32'(0));
    sb.delete();
  endtask

  task automatic check_reset_vals();
    chk("rst_load_ready", 32'(load_ready), 32'(1));
    chk("rst_ready", 32'(ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_take_valid", 32'(take_valid), 32'(0));
    chk("rst_take_card", 32'(take_card), 32'(0));
    chk("rst_talon_count", 32'(talon_count), 32'(0));
    chk("rst_stock_count", 32'(stock_count), 32'(0));
    chk("rst_stock_top0", 32'(stock_top0), 32'(0));
    chk("rst_stock_top1", 32'(stock_top1), 32'(0));
    chk("rst_stock_top2", 32'(stock_top2), 32'(0));
    chk("rst_recycle_count", 32'(recycle_count), 32'(0));
  endtask

  task automatic do_draw();
    exp_t e;
    int   n;
    int   req_cyc;
    @(negedge clk);
    draw_req = 1'b1;
    req_cyc  = cyc + 1;
    if (m_talon.size() > 0) begin
      n = (m_talon.size() < 3) ? m_talon.size() : 3;
      for (int i = 0; i < n; i++) m_stock.push_back(m_talon.pop_back() | 7'h01);
    end else if (m_stock.size() > 0) begin
      n = m_stock.size();
      while (m_stock.size() > 0) m_talon.push_back(m_stock.pop_back() & 7'h7E);
    end else begin
      n = 0;
    end
    e.is_take = 1'b0;
    e.card    = 7'h00;
    e.cyc     = req_cyc + n;
    e.tc      = m_talon.size();
    e.sc      = m_stock.size();
    e.top0    = (m_stock.size() > 0) ? m_stock[m_stock.size() - 1] : 7'h00;
    sb.push_back(e);
    @(negedge clk);
    draw_req = 1'b0;
    chk("busy_after_draw_req", 32'(busy), 32'(n > 0));
    drain(40);
  endtask

  task automatic do_take(input bit with_draw);
    exp_t e;
    @(negedge clk);
    take_req  = 1'b1;
    draw_req  = with_draw;
    e.is_take = 1'b1;
    e.cyc     = cyc + 1;
    e.card    = m_stock.pop_back();
    e.sc      = m_stock.size();
    e.tc      = m_talon.size();
    e.top0    = 7'h00;
    sb.push_back(e);
    @(negedge clk);
    take_req = 1'b0;
    draw_req = 1'b0;
    chk("busy_after_take", 32'(busy), 32'(0));
    drain(5);
  endtask

  logic [6:0] zl [8];

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_card  = 7'h00;
    load_last  = 1'b0;
    draw_req   = 1'b0;
    take_req   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;

    // Full 24-card load
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 23) begin
        chk("ready_before_last", 32'(ready), 32'(0));
        chk("talon_before_last", 32'(talon_count), 32'(23));
      end
      load_valid = 1'b1;
      load_card  = 7'h10 + 7'(i);
      load_last  = (i == 23);
      m_talon.push_back(load_card & 7'h7E);
    end
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("full_ready", 32'(ready), 32'(1));
    chk("full_talon_count", 32'(talon_count), 32'(24));
    chk("full_load_ready", 32'(load_ready), 32'(0));
    load_valid = 1'b1;
    load_card  = 7'h30;
    @(negedge clk);
    load_valid = 1'b0;
    chk("load_ignored_in_ready", 32'(talon_count), 32'(24));

    do_draw();
    chk("draw1_top0", 32'(stock_top0), 32'(7'h25));
    chk("draw1_top1", 32'(stock_top1), 32'(7'h27));
    chk("draw1_top2", 32'(stock_top2), 32'(7'h27));
    chk("draw1_talon", 32'(talon_count), 32'(21));
    chk("draw1_stock", 32'(stock_count), 32'(3));
    repeat (7) do_draw();
    chk("drained_talon", 32'(talon_count), 32'(0));
    chk("drained_stock", 32'(stock_count), 32'(24));
    chk("drained_top0", 32'(stock_top0), 32'(7'h11));

    do_draw();
    chk("recycle_count", 32'(recycle_count), 32'(1));
    chk("recycle_talon", 32'(talon_count), 32'(24));
    chk("recycle_stock", 32'(stock_count), 32'(0));
    do_draw();
    chk("redraw_top0", 32'(stock_top0), 32'(7'h25));
    chk("redraw_top2", 32'(stock_top2), 32'(7'h27));

    do_take(1'b1);
    chk("take_draw_card", 32'(take_card), 32'(7'h25));
    chk("take_draw_stock", 32'(stock_count), 32'(2));
    chk("take_draw_talon", 32'(talon_count), 32'(21));

    // Reset in the middle of a draw
    @(negedge clk);
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    chk("busy_before_abort", 32'(busy), 32'(1));
    rst = 1'b1;
    #1;
    check_reset_vals();
    m_talon.delete();
    m_stock.delete();
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Load with interleaved empty slots
    zl = '{7'h31, 7'h00, 7'h42, 7'h00, 7'h53, 7'h64, 7'h00, 7'h75};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_card  = zl[i];
      load_last  = (i == 7);
      if (zl[i] != 7'h00) m_talon.push_back(zl[i] & 7'h7E);
    end
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("zl_talon_count", 32'(talon_count), 32'(5));
    chk("zl_ready", 32'(ready), 32'(1));

    do_draw();
    chk("zl_draw1_top0", 32'(stock_top0), 32'(7'h53));
    chk("zl_draw1_talon", 32'(talon_count), 32'(2));
    do_draw();
    chk("short_draw_top0", 32'(stock_top0), 32'(7'h31));
    chk("short_draw_top1", 32'(stock_top1), 32'(7'h43));
    chk("short_draw_top2", 32'(stock_top2), 32'(7'h53));
    chk("short_draw_talon", 32'(talon_count), 32'(0));
    chk("short_draw_stock", 32'(stock_count), 32'(5));

    repeat (5) do_take(1'b0);
    chk("last_take_card", 32'(take_card), 32'(7'h75));
    chk("takes_stock", 32'(stock_count), 32'(0));
    @(negedge clk);
    take_req = 1'b1;
    @(negedge clk);
    take_req = 1'b0;
    chk("empty_take_no_valid", 32'(take_valid), 32'(0));

    do_draw();
    chk("empty_draw_talon", 32'(talon_count), 32'(0));
    chk("empty_draw_stock", 32'(stock_count), 32'(0));
    chk("empty_draw_recycles", 32'(recycle_count), 32'(0));

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
